// File: rtl/fetch_stage.sv
// fetch_stage: CPU front end. Owns the program counter, drives the instruction
// memory address/hold/clear controls, buffers returned words in a small
// circular prefetch queue and hands them to decode under a valid/stall
// handshake. Redirects from execute flush everything and restart fetch.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   - a word returning while the queue is empty and decode is ready
//               is forwarded to decode in the same cycle without being queued.
//   undefined - every word passes through the queue (one cycle minimum latency).
//
// DEPTH must lie in 2..8.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'd0,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] im_addr,
  output logic        im_hold,
  output logic        im_clear,
  input  logic        im_hit,
  input  logic [31:0] im_q,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] HOLD_LVL = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FULL,
    ST_FLUSH
  } fetch_state_e;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] word_mem_q [DEPTH];

  logic accept;
  logic bypass;
  logic push;
  logic pop;
  logic head_valid;

  // Pointer advance with wrap modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode: which of accept/push/pop happen this cycle.
  always_comb begin
    head_valid = (count_q != '0);
    accept     = im_hit && !redirect;
`ifdef FETCH_BYPASS_EN
    bypass     = !head_valid && im_hit && !stall && !redirect;
`else
    bypass     = 1'b0;
`endif
    push       = accept && !bypass;
    pop        = head_valid && !stall && !redirect;
  end

  // Next-state for pc, queue bookkeeping and the fetch state; redirect wins.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    state_d  = state_q;
    if (redirect) begin
      pc_d     = redirect_addr;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = ST_FLUSH;
    end else begin
      if (accept) pc_d = pc_q + 32'd1;
      if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      state_d = (count_d >= HOLD_LVL) ? ST_FULL : ST_RUN;
    end
  end

  // Fetch state machine and control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VECTOR;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Queue storage; contents are only observed while count says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      word_mem_q[wr_ptr_q] <= im_q;
    end
  end

  // Memory-side controls and decode-side outputs.
  always_comb begin
    im_addr     = pc_q;
    im_clear    = redirect;
    im_hold     = (state_q == ST_FULL) && !redirect;
    instr_valid = head_valid || bypass;
    instr       = 32'd0;
    instr_pc    = 32'd0;
    if (head_valid) begin
      instr    = word_mem_q[rd_ptr_q];
      instr_pc = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      instr    = im_q;
      instr_pc = pc_q;
    end
  end

`ifndef SYNTHESIS
  overflow_chk: assert property (@(posedge clk) disable iff (!reset_n)
                                 !(push && !pop && (count_q == CNT_MAX)));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a small instruction
// memory model and a scoreboard of expected {pc, word} pairs.
module tb_fetch_stage;

  localparam logic [31:0] RV       = 32'h0000_0100;
  localparam int          DEPTH    = 3;
  localparam logic [31:0] TAG_BASE = 32'hA000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] im_addr;
  logic        im_hold;
  logic        im_clear;
  logic        im_hit;
  logic [31:0] im_q;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      exp_q[$];
  int          n_cmp;
  int          n_mis;
  bit          mem_busy;
  bit          hold_prev;
  bit          saw_hit;
  bit          found;
  logic [31:0] exp_pc;

  fetch_stage #(
    .RESET_VECTOR (RV),
    .DEPTH        (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .im_addr       (im_addr),
    .im_hold       (im_hold),
    .im_clear      (im_clear),
    .im_hit        (im_hit),
    .im_q          (im_q),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Compare decode-side outputs against the scoreboard head at the negedge.
  task automatic checkOutput(input bit st, input bit rd);
    if (!rd) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check32("spurious_valid", 32'(instr_valid), 32'd0);
        end else begin
          check32("instr_pc", instr_pc, exp_q[0].pc);
          check32("instr", instr, exp_q[0].word);
          if (!st) void'(exp_q.pop_front());
        end
      end else begin
        check32("idle_instr", instr, 32'd0);
        check32("idle_pc", instr_pc, 32'd0);
      end
    end
  endtask

  // One clock cycle: drive controls, check memory-side outputs, run the
  // memory model (it registers im_hold, so it acts on last cycle's hold),
  // update the scoreboard, then check decode-side outputs.
  task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] ra);
    entry_t e;
    @(posedge clk);
    #1;
    stall         = st;
    redirect      = rd;
    redirect_addr = ra;
    im_hit        = 1'b0;
    im_q          = 32'd0;
    #1;
    check32("im_clear", 32'(im_clear), 32'(rd));
    check32("im_addr", im_addr, exp_pc);
    check32("im_hold", 32'(im_hold), 32'((exp_q.size() >= DEPTH - 1) && !rd));
    if (mem_busy) begin
      im_hit = 1'b1;
      im_q   = TAG_BASE + im_addr;
    end
    saw_hit = im_hit && !rd;
    if (rd) begin
      mem_busy = 1'b0;
      exp_q.delete();
      exp_pc = ra;
    end else if (im_hit) begin
      mem_busy = 1'b0;
      e.pc     = exp_pc;
      e.word   = TAG_BASE + exp_pc;
      exp_q.push_back(e);
      exp_pc   = exp_pc + 32'd1;
    end else if (!hold_prev) begin
      mem_busy = 1'b1;
    end
    hold_prev = im_hold;
    @(negedge clk);
    checkOutput(st, rd);
  endtask

  // Asynchronous reset for two edges, checking outputs while it is held.
  task automatic doReset();
    reset_n   = 1'b0;
    im_hit    = 1'b0;
    stall     = 1'b0;
    redirect  = 1'b0;
    mem_busy  = 1'b0;
    hold_prev = 1'b0;
    exp_q.delete();
    exp_pc    = RV;
    #1;
    check32("rst_valid", 32'(instr_valid), 32'd0);
    check32("rst_instr", instr, 32'd0);
    check32("rst_pc", instr_pc, 32'd0);
    check32("rst_clear", 32'(im_clear), 32'd0);
    check32("rst_hold", 32'(im_hold), 32'd0);
    check32("rst_addr", im_addr, RV);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Directed sequence covering streaming, fill under stall, redirects, wrap
  // and a mid-transaction reset.
  initial begin
    n_cmp         = 0;
    n_mis         = 0;
    reset_n       = 1'b1;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'd0;
    im_hit        = 1'b0;
    im_q          = 32'd0;
    mem_busy      = 1'b0;
    hold_prev     = 1'b0;
    exp_pc        = RV;
    $display("[TB] fetch_stage bench, DEPTH=%0d bypass=%0d", DEPTH, BYPASS);
    #2;
    doReset();

    // Streaming from reset and first-word latency.
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      if (saw_hit) found = 1'b1;
    end
    check32("first_hit_seen", 32'(found), 32'd1);
    check32("lat_same_cycle", 32'(instr_valid), 32'(BYPASS));
    applyStimulus(1'b0, 1'b0, 32'd0);
    check32("lat_next_cycle", 32'(instr_valid), 32'(!BYPASS));
    repeat (12) applyStimulus(1'b0, 1'b0, 32'd0);
    check32("stream_backlog", 32'(exp_q.size() <= 1), 32'd1);

    // Fill the queue under stall, then drain in order.
    repeat (10) applyStimulus(1'b1, 1'b0, 32'd0);
    check32("fill_hold", 32'(im_hold), 32'd1);
    check32("fill_valid", 32'(instr_valid), 32'd1);
    check32("fill_level", 32'(exp_q.size()), 32'(DEPTH));
    repeat (10) applyStimulus(1'b0, 1'b0, 32'd0);
    check32("drain_backlog", 32'(exp_q.size() <= 1), 32'd1);

    // Redirect coincident with a returning word.
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (mem_busy) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'd0);
    end
    check32("redir_hit_ready", 32'(found), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0040);
    applyStimulus(1'b0, 1'b0, 32'd0);
    check32("redir_valid_after", 32'(instr_valid), 32'd0);
    check32("redir_addr_after", im_addr, 32'h0000_0040);
    check32("redir_clear_after", 32'(im_clear), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      if (instr_valid) found = 1'b1;
    end
    check32("redir_first_seen", 32'(found), 32'd1);
    check32("redir_first_pc", instr_pc, 32'h0000_0040);

    // Redirect while two entries are queued and decode is stalled.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      if (exp_q.size() >= 2) found = 1'b1;
    end
    check32("two_queued_seen", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0);
    check32("pre_flush_valid", 32'(instr_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200);
    applyStimulus(1'b1, 1'b0, 32'd0);
    check32("flush_valid", 32'(instr_valid), 32'd0);
    check32("flush_addr", im_addr, 32'h0000_0200);

    // PC wrap from 0xFFFFFFFF to 0.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      if (saw_hit) found = 1'b1;
    end
    check32("wrap_hit_seen", 32'(found), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0);
    check32("wrap_addr", im_addr, 32'd0);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'd0);

    // Reset while a transaction is in flight restarts at the reset vector.
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (mem_busy) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'd0);
    end
    check32("midrst_busy", 32'(found), 32'd1);
    @(posedge clk);
    #3;
    doReset();
    repeat (10) applyStimulus(1'b0, 1'b0, 32'd0);
    check32("midrst_backlog", 32'(exp_q.size() <= 1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
